icb_regbank_sram_slave: RTL and testbench

//  Parametrised ICB slave: NREG 32-bit control/status registers plus an SRAM window,

---
 rtl/icb_regbank_sram_slave.sv | 177 +++++++++++++++++
 tb/tb_icb_regbank_sram_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/icb_regbank_sram_slave.sv
// ICB slave exposing NREG 32-bit control/status registers and an SRAM window.
// Responses flow through a one-cycle stage (s1) and an in-order FIFO. The FIFO
// reserves a slot for every accepted command, so backpressure on the response
// channel can never drop a response.
module icb_regbank_sram_slave #(
  parameter int unsigned     NREG      = 8,
  parameter logic [NREG-1:0] RO_MASK   = '0,
  parameter int unsigned     SRAM_AW   = 13,
  parameter int unsigned     SEL_BIT   = 15,
  parameter int unsigned     RSP_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 icb_cmd_valid,
  output logic                 icb_cmd_ready,
  input  logic                 icb_cmd_read,
  input  logic [31:0]          icb_cmd_addr,
  input  logic [31:0]          icb_cmd_wdata,
  input  logic [3:0]           icb_cmd_wmask,
  output logic                 icb_rsp_valid,
  input  logic                 icb_rsp_ready,
  output logic [31:0]          icb_rsp_rdata,
  output logic                 icb_rsp_err,
  output logic [NREG*32-1:0]   reg_q,
  output logic [NREG-1:0]      reg_wr_pulse,
  input  logic [NREG*32-1:0]   hw_rd_data,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [3:0]           sram_wmask,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic [NREG*32-1:0] regs_q, regs_d;
  logic [NREG-1:0]    pulse_q, pulse_d;
  logic               s1_valid_q, s1_valid_d;
  logic [31:0]        s1_rdata_q, s1_rdata_d;
  logic               s1_err_q, s1_err_d;
  logic               s1_sram_rd_q, s1_sram_rd_d;
  logic [31:0]        fifo_rdata_q [RSP_DEPTH];
  logic [31:0]        fifo_rdata_d [RSP_DEPTH];
  logic               fifo_err_q [RSP_DEPTH];
  logic               fifo_err_d [RSP_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;

  logic        accept, sel_sram, dec_hit, dec_ro, cmd_err, push, pop;
  logic [3:0]  reg_idx;
  logic [31:0] dec_rdata, push_rdata;
  logic [CntW:0] outstanding;
  logic        unused_bits;

  // Slots already promised (stage 1 plus FIFO) bound acceptance; registered state only.
  assign outstanding   = {1'b0, count_q} + {{CntW{1'b0}}, s1_valid_q};
  assign icb_cmd_ready = outstanding < (CntW + 1)'(RSP_DEPTH);
  assign accept        = icb_cmd_valid & icb_cmd_ready;
  assign sel_sram      = icb_cmd_addr[SEL_BIT];
  assign reg_idx       = icb_cmd_addr[5:2];
  assign unused_bits   = ^{icb_cmd_addr, hw_rd_data};

  // Register decode: hit/RO flags and the read value for the addressed register.
  always_comb begin
    dec_hit   = 1'b0;
    dec_ro    = 1'b0;
    dec_rdata = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (reg_idx == 4'(i)) begin
        dec_hit   = 1'b1;
        dec_ro    = RO_MASK[i];
        dec_rdata = RO_MASK[i] ? hw_rd_data[32*i +: 32] : regs_q[32*i +: 32];
      end
    end
  end

  assign cmd_err = ~sel_sram & (~dec_hit | (~icb_cmd_read & dec_ro));

  // Byte-masked register writes and the one-cycle write pulse.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (accept && !sel_sram && !icb_cmd_read && !cmd_err) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (reg_idx == 4'(i)) begin
          pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < 4; b++) begin
            if (icb_cmd_wmask[b]) regs_d[32*i + 8*b +: 8] = icb_cmd_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Stage 1 captures the response of the command accepted this cycle.
  always_comb begin
    s1_valid_d   = accept;
    s1_err_d     = accept & cmd_err;
    s1_sram_rd_d = accept & sel_sram & icb_cmd_read;
    s1_rdata_d   = (accept && !sel_sram && icb_cmd_read && !cmd_err) ? dec_rdata : '0;
  end

  // SRAM strobes are live only in the accept cycle.
  always_comb begin
    sram_en    = accept & sel_sram;
    sram_we    = sram_en & ~icb_cmd_read;
    sram_wmask = sram_en ? icb_cmd_wmask : '0;
    sram_addr  = sram_en ? icb_cmd_addr[SRAM_AW+1:2] : '0;
    sram_wdata = sram_en ? icb_cmd_wdata : '0;
  end

  // Response FIFO next state; simultaneous push and pop leave the count unchanged.
  always_comb begin
    push         = s1_valid_q;
    pop          = icb_rsp_valid & icb_rsp_ready;
    push_rdata   = s1_sram_rd_q ? sram_rdata : s1_rdata_q;
    fifo_rdata_d = fifo_rdata_q;
    fifo_err_d   = fifo_err_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (push) begin
      fifo_rdata_d[wr_ptr_q] = push_rdata;
      fifo_err_d[wr_ptr_q]   = s1_err_q;
      wr_ptr_d = (wr_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  // Response outputs from the FIFO head; zero when empty.
  always_comb begin
    icb_rsp_valid = (count_q != '0);
    icb_rsp_rdata = icb_rsp_valid ? fifo_rdata_q[rd_ptr_q] : '0;
    icb_rsp_err   = icb_rsp_valid & fifo_err_q[rd_ptr_q];
  end

  assign reg_q        = regs_q;
  assign reg_wr_pulse = pulse_q;

  // Control state with asynchronous reset; reset discards all pending responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q       <= '0;
      pulse_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_rdata_q   <= '0;
      s1_err_q     <= 1'b0;
      s1_sram_rd_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      regs_q       <= regs_d;
      pulse_q      <= pulse_d;
      s1_valid_q   <= s1_valid_d;
      s1_rdata_q   <= s1_rdata_d;
      s1_err_q     <= s1_err_d;
      s1_sram_rd_q <= s1_sram_rd_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    fifo_rdata_q <= fifo_rdata_d;
    fifo_err_q   <= fifo_err_d;
  end

endmodule

// File: tb/tb_icb_regbank_sram_slave.sv
// Scoreboard bench for icb_regbank_sram_slave (NREG=6, register 0 read-only).
module tb_icb_regbank_sram_slave;

  localparam int unsigned NREG = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              icb_cmd_valid = 1'b0, icb_cmd_ready, icb_cmd_read = 1'b0;
  logic [31:0]       icb_cmd_addr = '0, icb_cmd_wdata = '0;
  logic [3:0]        icb_cmd_wmask = '0;
  logic              icb_rsp_valid, icb_rsp_ready = 1'b1, icb_rsp_err;
  logic [31:0]       icb_rsp_rdata;
  logic [NREG*32-1:0] reg_q, hw_rd_data;
  logic [NREG-1:0]   reg_wr_pulse;
  logic              sram_en, sram_we;
  logic [3:0]        sram_wmask;
  logic [12:0]       sram_addr;
  logic [31:0]       sram_wdata, sram_rdata = '0;

  icb_regbank_sram_slave #(
    .NREG(NREG), .RO_MASK(6'b000001), .SRAM_AW(13), .SEL_BIT(15), .RSP_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .hw_rd_data(hw_rd_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: read data one cycle after the strobe.
  logic [31:0] mem [8192];
  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    bit          strict;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   strict_lat = 1'b1;
  logic        last_en, last_we;
  logic [12:0] last_addr;
  logic [31:0] last_wdata;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input string name, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] m,
                       input logic [31:0] erd, input logic eerr);
    bit acc = 1'b0;
    exp_t e;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wd;   icb_cmd_wmask = m;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      if (icb_cmd_ready) begin
        acc = 1'b1;
        e.rdata = erd; e.err = eerr; e.acc_cyc = cyc; e.strict = strict_lat; e.name = name;
        sb.push_back(e);
        last_en = sram_en; last_we = sram_we; last_addr = sram_addr; last_wdata = sram_wdata;
      end
      @(posedge clk);
    end
    #1 icb_cmd_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout %s: got no ready expected ready", name);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a response.
  initial forever begin
    @(negedge clk);
    if (!rst && icb_rsp_valid && icb_rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rdata %h err %b expected none",
                 icb_rsp_rdata, icb_rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_rdata"}, icb_rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'b0, icb_rsp_err}, {31'b0, e.err});
        if (e.strict) chk({e.name, "_latency"}, cyc - e.acc_cyc, 2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    hw_rd_data = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003,
                  32'h2222_0002, 32'h1111_0001, 32'hCAFE_0001};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, icb_rsp_valid}, 0);
    chk("rst_cmd_ready", {31'b0, icb_cmd_ready}, 1);
    chk("rst_reg_q_nonzero", {31'b0, |reg_q}, 0);
    chk("rst_pulse", {26'b0, reg_wr_pulse}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: full write to reg1
    issue("wr_reg1", 1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("wr_pulse_set", {26'b0, reg_wr_pulse}, 32'h2);
    chk("reg1_full", reg_q[63:32], 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_pulse_clear", {26'b0, reg_wr_pulse}, 0);
    @(posedge clk); #1;

    // 2: byte-masked write then read
    issue("wr_reg1_b1", 1'b0, 32'h0000_0004, 32'h0000_AA00, 4'h2, 32'h0, 1'b0);
    issue("rd_reg1", 1'b1, 32'h0000_0004, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0);
    issue("wr_reg2_m5", 1'b0, 32'h0000_0008, 32'h1122_3344, 4'h5, 32'h0, 1'b0);
    issue("rd_reg2", 1'b1, 32'h0000_0008, 32'h0, 4'h0, 32'h0022_0044, 1'b0);
    issue("wr_reg3_m0", 1'b0, 32'h0000_000C, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    issue("rd_reg3", 1'b1, 32'h0000_000C, 32'h0, 4'h0, 32'h0, 1'b0);

    // 3: SRAM window
    issue("wr_sram4", 1'b0, 32'h0000_8010, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    chk("sram_wr_strobe", {30'b0, last_en, last_we}, 32'h3);
    chk("sram_wr_addr", {19'b0, last_addr}, 32'h4);
    chk("sram_wr_data", last_wdata, 32'h1234_5678);
    issue("rd_sram4", 1'b1, 32'h0000_8010, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    chk("sram_rd_strobe", {30'b0, last_en, last_we}, 32'h2);
    chk("sram_rd_addr", {19'b0, last_addr}, 32'h4);
    issue("rd_sram4_hi", 1'b1, 32'hF0FF_8013, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("sram_idle_en", {31'b0, sram_en}, 0);
    @(posedge clk); #1;

    // 5: register errors and RO register
    issue("rd_reg7_err", 1'b1, 32'h0000_001C, 32'h0, 4'h0, 32'h0, 1'b1);
    issue("rd_reg6_err", 1'b1, 32'h0000_0018, 32'h0, 4'h0, 32'h0, 1'b1);
    issue("rd_reg5_ok", 1'b1, 32'h0000_0014, 32'h0, 4'h0, 32'h0, 1'b0);
    issue("wr_reg0_ro", 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    chk("ro_no_pulse", {26'b0, reg_wr_pulse}, 0);
    chk("ro_reg_q", reg_q[31:0], 32'h0);
    @(posedge clk); #1;
    issue("rd_reg0_hw", 1'b1, 32'h0000_0000, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0);

    // 4: backpressure, two in flight then a stalled third
    repeat (4) @(posedge clk);
    #1;
    strict_lat = 1'b0;
    icb_rsp_ready = 1'b0;
    issue("bp_rd_reg1", 1'b1, 32'h0000_0004, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0);
    issue("bp_rd_sram4", 1'b1, 32'h0000_8010, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    fork
      issue("bp_rd_reg0", 1'b1, 32'h0000_0000, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("bp_cmd_ready_low", {31'b0, icb_cmd_ready}, 0);
        chk("bp_queued", sb.size(), 2);
        @(posedge clk); #1;
        icb_rsp_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drained", sb.size(), 0);

    // 6: reset with responses pending
    icb_rsp_ready = 1'b0;
    issue("rst_rd_a", 1'b1, 32'h0000_0004, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0);
    issue("rst_rd_b", 1'b1, 32'h0000_0008, 32'h0, 4'h0, 32'h0022_0044, 1'b0);
    @(negedge clk);
    chk("pre_rst_rsp_valid", {31'b0, icb_rsp_valid}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_async_rsp_valid", {31'b0, icb_rsp_valid}, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    icb_rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", {31'b0, icb_cmd_ready}, 1);
    chk("post_rst_reg_q_nonzero", {31'b0, |reg_q}, 0);
    strict_lat = 1'b1;
    issue("post_rst_rd_reg1", 1'b1, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 1'b0);

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("final_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
